// File: rtl/pwm_pkg.sv
// Shared types and defaults for the PWM receive path (synchronizer + meter).
package pwm_pkg;

  localparam int W_DEF       = 8;
  localparam int TIMEOUT_DEF = 512;
  localparam int SYNC_DEF    = 2;

  typedef enum logic {
    WAIT_EDGE = 1'b0,
    MEASURE   = 1'b1
  } state_e;

  // High-time and period counters carry one extra bit so a full-scale period fits.
  function automatic int cnt_width(input int w);
    return w + 1;
  endfunction

endpackage

// File: rtl/pwm_sync.sv
// Brings the asynchronous PWM input into the CLOCK_50 domain and flags its edges.
module pwm_sync
  import pwm_pkg::*;
#(
  parameter int SYNC_STAGES = SYNC_DEF
) (
  input  logic CLOCK_50,
  input  logic Resetn,
  input  logic PwmIn,
  output logic s,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   s_q, s_d;
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;

  // Edge flags are registered, so s is the delayed level aligned with rise/fall.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], PwmIn};
    s_d    = sync_q[SYNC_STAGES-1];
    rise_d = sync_q[SYNC_STAGES-1] & ~s_q;
    fall_d = ~sync_q[SYNC_STAGES-1] & s_q;
  end

  always_ff @(posedge CLOCK_50) begin
    if (!Resetn) begin
      sync_q <= '0;
      s_q    <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      s_q    <= s_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign s    = s_q;
  assign rise = rise_q;
  assign fall = fall_q;

endmodule

// File: rtl/pwm_meter.sv
// Measures high time and period of PwmIn between rising edges; flags stuck inputs.
//   state     | meaning
//   WAIT_EDGE | discarding a partial period, waiting for a rise to start counting
//   MEASURE   | counting high time and period since the last rise
module pwm_meter
  import pwm_pkg::*;
#(
  parameter int W           = W_DEF,
  parameter int TIMEOUT     = TIMEOUT_DEF,
  parameter int SYNC_STAGES = SYNC_DEF
) (
  input  logic         CLOCK_50,
  input  logic         Resetn,
  input  logic         PwmIn,
  output logic [W-1:0] Duty,
  output logic [W:0]   Period,
  output logic         Valid,
  output logic         Stuck
);

  localparam int               CW      = cnt_width(W);
  localparam int               TW      = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0]    CNT_MAX = '1;
  localparam logic [TW-1:0]    T_LAST  = TW'(TIMEOUT - 1);

  logic s, rise, fall;

  pwm_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .CLOCK_50(CLOCK_50),
    .Resetn  (Resetn),
    .PwmIn   (PwmIn),
    .s       (s),
    .rise    (rise),
    .fall    (fall)
  );

  state_e          state_q, state_d;
  logic [CW-1:0]   hcnt_q, hcnt_d;
  logic [CW-1:0]   pcnt_q, pcnt_d;
  logic [TW-1:0]   tcnt_q, tcnt_d;
  logic [W-1:0]    duty_q, duty_d;
  logic [W:0]      period_q, period_d;
  logic            valid_q, valid_d;
  logic            stuck_q, stuck_d;
  logic            timeout;

  always_comb begin
    state_d  = state_q;
    hcnt_d   = hcnt_q;
    pcnt_d   = pcnt_q;
    tcnt_d   = tcnt_q;
    duty_d   = duty_q;
    period_d = period_q;
    valid_d  = 1'b0;
    stuck_d  = stuck_q;
    timeout  = 1'b0;

    // Any edge restarts the watchdog, so a rise always beats a coincident timeout.
    if (rise || fall) begin
      tcnt_d = '0;
    end else if (tcnt_q == T_LAST) begin
      tcnt_d  = '0;
      timeout = 1'b1;
    end else begin
      tcnt_d = tcnt_q + TW'(1);
    end

    case (state_q)
      WAIT_EDGE: begin
        if (rise) begin
          hcnt_d  = CW'(1);
          pcnt_d  = CW'(1);
          state_d = MEASURE;
        end
      end
      MEASURE: begin
        if (rise) begin
          duty_d   = hcnt_q[W] ? '1 : hcnt_q[W-1:0];
          period_d = pcnt_q;
          valid_d  = 1'b1;
          stuck_d  = 1'b0;
          hcnt_d   = CW'(1);
          pcnt_d   = CW'(1);
        end else begin
          pcnt_d = (pcnt_q == CNT_MAX) ? pcnt_q : pcnt_q + CW'(1);
          if (s && (hcnt_q != CNT_MAX)) begin
            hcnt_d = hcnt_q + CW'(1);
          end
        end
      end
      default: state_d = WAIT_EDGE;
    endcase

    if (timeout) begin
      duty_d   = s ? '1 : '0;
      period_d = '0;
      stuck_d  = 1'b1;
      valid_d  = 1'b1;
      state_d  = WAIT_EDGE;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (!Resetn) begin
      state_q  <= WAIT_EDGE;
      hcnt_q   <= '0;
      pcnt_q   <= '0;
      tcnt_q   <= '0;
      duty_q   <= '0;
      period_q <= '0;
      valid_q  <= 1'b0;
      stuck_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      hcnt_q   <= hcnt_d;
      pcnt_q   <= pcnt_d;
      tcnt_q   <= tcnt_d;
      duty_q   <= duty_d;
      period_q <= period_d;
      valid_q  <= valid_d;
      stuck_q  <= stuck_d;
    end
  end

  assign Duty   = duty_q;
  assign Period = period_q;
  assign Valid  = valid_q;
  assign Stuck  = stuck_q;

endmodule

// File: doc/pwm_meter.md
Name: pwm_meter

Overview:
- Receive side of the LED-dimming PWM path.
- Samples an external PWM waveform (e.g. from the 256-cycle, 8-bit PWM generator) on CLOCK_50 and measures its high time and period per cycle.
- Reports the duty as an 8-bit value comparable to the generator's SW setting.
- Detects stuck-low and stuck-high inputs (0% / ~100% duty) by timeout.

Parameters:
- W, 8, duty width; full-scale period is 2^W clocks.
- TIMEOUT, 512, clocks without any input edge before the input is declared stuck.
- SYNC_STAGES, 2, flops in the input synchronizer (minimum 2).

Ports:
- CLOCK_50  in  1  system clock; all logic on its rising edge.
- Resetn  in  1  reset, synchronous, active-low.
- PwmIn  in  1  asynchronous PWM input.
- Duty  out  W  last measured high-time count, saturated.
- Period  out  W+1  last measured period in clocks, saturated.
- Valid  out  1  one-cycle pulse when Duty/Period update.
- Stuck  out  1  level; set on timeout, cleared by the next normal measurement.

Behaviour:
- Reset (Resetn=0 at a clock edge): Duty=0, Period=0, Valid=0, Stuck=0. Synchronizer flops=0, counters=0, state=WAIT_EDGE.
- Synchronizer: PwmIn passes through SYNC_STAGES flops giving s. sp = s delayed 1 clock. rise = s & ~sp; fall = ~s & sp.
- Counters:
  - hcnt, pcnt: W+1 bits each, saturating at 2^(W+1)-1, never wrap.
  - tcnt: cycles since the last rise or fall, sized for TIMEOUT.
- State WAIT_EDGE: discards the partial first period.
  - On rise: hcnt=1, pcnt=1, tcnt=0, go MEASURE.
  - No publish occurs in this state.
- State MEASURE: each cycle pcnt+=1 and hcnt+=s.
  - On rise: publish on the following edge:
    - Duty = (hcnt >= 2^W) ? all-ones : hcnt[W-1:0].
    - Period = pcnt.
    - Valid=1 for exactly one cycle; Stuck=0.
    - Same edge: hcnt=1, pcnt=1, tcnt=0; stay MEASURE.
  - Measured window is from the previous rise cycle (inclusive) to the current rise cycle (exclusive).
- Timeout: in any state, when tcnt reaches TIMEOUT-1 with no edge:
  - Duty = s ? all-ones : 0; Period = 0; Stuck=1; Valid pulses.
  - tcnt=0; go WAIT_EDGE.
  - While the input stays stuck, a Valid pulse repeats every TIMEOUT clocks.
- Latency: PwmIn rising edge to Valid is SYNC_STAGES+2 clocks (sync, edge detect, publish register).
- Simultaneous events: rise and timeout in the same cycle resolve to rise (normal measurement wins).
- Duty and Period hold their value between Valid pulses.
- Reset mid-period: everything returns to reset values. The first publish after release comes only after two rises.
- Glitches shorter than 1 clock may be lost; no filtering beyond the synchronizer.

Decomposition:
- pwm_pkg holds:
  - State encoding: WAIT_EDGE=1'b0, MEASURE=1'b1.
  - Defaults for W and TIMEOUT.
  - Saturating-increment width constant W+1.
- Sub-module pwm_sync: SYNC_STAGES-flop synchronizer plus edge detector; outputs s, rise, fall; uses the same CLOCK_50/Resetn.
- pwm_meter holds the FSM, counters and output registers.

Test Plan:
- Reset, then drive a 256-clock period with 128 high (SW=128 equivalent) -> no Valid for the first period; then Valid once per 256 clocks with Duty=128, Period=256, Stuck=0.
- High 255 of 256 (SW=255) -> Duty=255, Period=256. High 1 of 256 -> Duty=1, Period=256.
- PwmIn held 0 for 2000 clocks -> Valid pulses every 512 clocks with Duty=0, Period=0, Stuck=1. Then resume 64/256 -> first normal Valid gives Duty=64 and Stuck=0.
- PwmIn held 1 for 2000 clocks -> Valid every 512 clocks with Duty=255, Stuck=1.
- Period 600 with 300 high -> Duty=255 (saturated), Period=511 (saturated).
- Assert Resetn=0 for 3 clocks mid-high -> outputs zero on the next edge; after release, Valid appears only after the second observed rise. Also check latency from the first counted PwmIn rise to Valid is exactly 4 clocks.
